i2si_bist_ctrl: RTL and testbench

I2SI_BIST_CTRL -- requirements
Module: i2si_bist_ctrl

---
 rtl/i2si_bist_ctrl_if.sv | 37 +++
 rtl/i2si_bist_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_i2si_bist_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2si_bist_ctrl_if.sv
// Signal bundle around the I2S BIST controller: register-file control and
// status, BIST pattern generator, functional TX path, loopback RX path and
// the muxed feed towards the serializer.
interface i2si_bist_ctrl_if;
  logic        sck_transition;
  logic        rf_bist_start;
  logic        rf_bist_abort;
  logic [15:0] rf_bist_frames;
  logic [31:0] gen_data;
  logic        gen_xfc;
  logic [31:0] tx_data;
  logic        tx_xfc;
  logic [31:0] rx_data;
  logic        rx_xfc;
  logic        bist_gen_rst_n;
  logic [31:0] i2si_out_data;
  logic        i2si_out_xfc;
  logic        bist_busy;
  logic        bist_done;
  logic        bist_pass;
  logic [7:0]  bist_err_cnt;
  logic        bist_timeout;

  modport master (
    output sck_transition, rf_bist_start, rf_bist_abort, rf_bist_frames,
           gen_data, gen_xfc, tx_data, tx_xfc, rx_data, rx_xfc,
    input  bist_gen_rst_n, i2si_out_data, i2si_out_xfc,
           bist_busy, bist_done, bist_pass, bist_err_cnt, bist_timeout
  );

  modport slave (
    input  sck_transition, rf_bist_start, rf_bist_abort, rf_bist_frames,
           gen_data, gen_xfc, tx_data, tx_xfc, rx_data, rx_xfc,
    output bist_gen_rst_n, i2si_out_data, i2si_out_xfc,
           bist_busy, bist_done, bist_pass, bist_err_cnt, bist_timeout
  );
endinterface

// File: rtl/i2si_bist_ctrl.sv
// I2S loopback BIST controller.
// Sequences IDLE -> SYNC -> RUN -> DRAIN -> DONE, steers the serializer
// between the BIST generator and the functional TX path, and (optionally)
// compares looped-back RX frames against an expected-frame FIFO.
// Build option: define I2SI_BIST_CHECK_EN to compile in the expected-frame
// FIFO, RX compare, error counter and drain timeout. Without it the test
// simply counts generator frames and always reports pass.
module i2si_bist_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [7:0]  DRAIN_TIMEOUT = 8'd64
) (
  input logic             clk,
  input logic             rst,
  i2si_bist_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, DONE} state_t;

`ifdef I2SI_BIST_CHECK_EN
  localparam state_t LAST_STATE = DRAIN;
`else
  localparam state_t LAST_STATE = DONE;
`endif

  state_t      state, state_nxt;
  logic [15:0] frames_q, frames_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic        start_clr;
  logic        flush;
  logic        push_req, pop_req;
  logic        drain_to;
  logic        gen_rst_n_nxt;
  logic        gen_rst_n_q, busy_q, done_q, pass_q, timeout_q;
  logic        timeout_nxt;
  logic [7:0]  err_cnt, err_nxt;
  logic        active;

  assign active = (state == SYNC) || (state == RUN) || (state == DRAIN);

`ifdef I2SI_BIST_CHECK_EN
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, do_push, do_pop, err_hit;
  logic [7:0]    to_cnt, to_inc;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign do_push    = push_req && !fifo_full;
  assign do_pop     = pop_req && !fifo_empty;
  assign to_inc     = to_cnt + 8'd1;
  // Underflow, overflow and data mismatch are OR-ed so a cycle counts once.
  // The compare uses the head as it stood before any same-cycle push.
  assign err_hit    = (pop_req && fifo_empty) || (push_req && fifo_full) ||
                      (do_pop && (fifo_mem[rd_ptr] != bus.rx_data));
`endif

  // Next-state logic; abort overrides everything, including a start.
  always_comb begin
    state_nxt     = state;
    frames_nxt    = frames_q;
    frame_cnt_nxt = frame_cnt;
    start_clr     = 1'b0;
    flush         = 1'b0;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    drain_to      = 1'b0;
    gen_rst_n_nxt = 1'b1;
    if (bus.rf_bist_abort) begin
      state_nxt = IDLE;
      flush     = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.rf_bist_start) begin
            start_clr     = 1'b1;
            flush         = 1'b1;
            frames_nxt    = bus.rf_bist_frames;
            frame_cnt_nxt = '0;
            if (bus.rf_bist_frames == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt     = SYNC;
              gen_rst_n_nxt = 1'b0;
            end
          end
        end
        SYNC, RUN: begin
          pop_req = bus.rx_xfc;
          if (bus.gen_xfc) begin
            push_req      = 1'b1;
            frame_cnt_nxt = frame_cnt + 16'd1;
            state_nxt     = (frame_cnt_nxt == frames_q) ? LAST_STATE : RUN;
          end
        end
        DRAIN: begin
`ifdef I2SI_BIST_CHECK_EN
          pop_req = bus.rx_xfc;
          if (fifo_empty) begin
            state_nxt = DONE;
          end else if (bus.sck_transition && !bus.rx_xfc &&
                       (to_inc == DRAIN_TIMEOUT)) begin
            drain_to  = 1'b1;
            state_nxt = DONE;
          end
`else
          state_nxt = DONE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef I2SI_BIST_CHECK_EN
  // Saturating error count and sticky timeout, both cleared by a start.
  always_comb begin
    err_nxt     = err_cnt;
    timeout_nxt = timeout_q | drain_to;
    if (start_clr) begin
      err_nxt     = '0;
      timeout_nxt = 1'b0;
    end else if (err_hit && (err_cnt != 8'hFF)) begin
      err_nxt = err_cnt + 8'd1;
    end
  end

  // Expected-frame FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (!do_push && do_pop) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  // Expected-frame storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= bus.gen_data;
  end

  // Drain watchdog: counts serial clock pulses since the last RX frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   to_cnt <= '0;
    else if ((state != DRAIN) || bus.rx_xfc)   to_cnt <= '0;
    else if (bus.sck_transition)               to_cnt <= to_inc;
  end
`else
  // Frame-count-only build: no checking, result is always a pass.
  always_comb begin
    err_nxt     = '0;
    timeout_nxt = 1'b0;
  end

  logic unused_nocheck;
  assign unused_nocheck = ^{bus.rx_data, bus.rx_xfc, bus.sck_transition,
                            push_req, pop_req, flush, drain_to, start_clr,
                            DRAIN_TIMEOUT, FIFO_DEPTH[7:0]};
`endif

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frames_q    <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      timeout_q   <= 1'b0;
      gen_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      frames_q    <= frames_nxt;
      frame_cnt   <= frame_cnt_nxt;
      err_cnt     <= err_nxt;
      timeout_q   <= timeout_nxt;
      gen_rst_n_q <= gen_rst_n_nxt;
      busy_q      <= (state_nxt == SYNC) || (state_nxt == RUN) || (state_nxt == DRAIN);
      done_q      <= (state_nxt == DONE);
      pass_q      <= (state_nxt == DONE) && (err_nxt == '0) && !timeout_nxt;
    end
  end

  assign bus.bist_gen_rst_n = gen_rst_n_q;
  assign bus.bist_busy      = busy_q;
  assign bus.bist_done      = done_q;
  assign bus.bist_pass      = pass_q;
  assign bus.bist_err_cnt   = err_cnt;
  assign bus.bist_timeout   = timeout_q;
  assign bus.i2si_out_data  = active ? bus.gen_data : bus.tx_data;
  assign bus.i2si_out_xfc   = active ? bus.gen_xfc  : bus.tx_xfc;

endmodule

// File: tb/tb_i2si_bist_ctrl.sv
// Bench for i2si_bist_ctrl: a vector table for the control/mux behaviour
// shared by both builds, then hand-written multi-cycle sequences for the
// build selected by I2SI_BIST_CHECK_EN.
module tb_i2si_bist_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned busy_cyc = 0;

  i2si_bist_ctrl_if ifc ();

  i2si_bist_ctrl #(
    .FIFO_DEPTH   (4),
    .DRAIN_TIMEOUT(8'd64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, abort;
    logic [15:0] frames;
    logic        gx;
    logic [31:0] gd;
    logic        tx;
    logic [31:0] td;
    logic        rx;
    logic [31:0] rd;
    logic        e_busy, e_done, e_pass, e_grst, e_xfc;
    logic [31:0] e_data;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ifc.bist_busy) busy_cyc++;
  endtask

  task automatic idle_inputs();
    ifc.sck_transition = 1'b0;
    ifc.rf_bist_start  = 1'b0;
    ifc.rf_bist_abort  = 1'b0;
    ifc.rf_bist_frames = '0;
    ifc.gen_data       = '0;
    ifc.gen_xfc        = 1'b0;
    ifc.tx_data        = 32'h7000_0000;
    ifc.tx_xfc         = 1'b0;
    ifc.rx_data        = '0;
    ifc.rx_xfc         = 1'b0;
  endtask

  task automatic add(input logic st, ab, input logic [15:0] fr,
                     input logic gx, input logic [31:0] gd,
                     input logic tx, input logic [31:0] td,
                     input logic rx, input logic [31:0] rd,
                     input logic eb, ed, ep, eg, ex,
                     input logic [31:0] edat, input logic [7:0] ee);
    vec_t v;
    v.start = st; v.abort = ab; v.frames = fr;
    v.gx = gx; v.gd = gd; v.tx = tx; v.td = td; v.rx = rx; v.rd = rd;
    v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_grst = eg; v.e_xfc = ex;
    v.e_data = edat; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic start_test(input int n);
    ifc.rf_bist_start  = 1'b1;
    ifc.rf_bist_frames = 16'(n);
    step();
    ifc.rf_bist_start  = 1'b0;
  endtask

  function automatic logic [31:0] gd(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

`ifdef I2SI_BIST_CHECK_EN
  // rx trails the generator by two frames; selected frames get bit 0 flipped.
  task automatic run_lag(input int n, input int c1, input int c2, input bit all_bad);
    logic [31:0] rdv;
    busy_cyc = 0;
    start_test(n);
    for (int i = 1; i <= n + 2; i++) begin
      if (i <= n) begin
        ifc.gen_xfc  = 1'b1;
        ifc.gen_data = gd(i);
      end
      if (i >= 3) begin
        rdv = gd(i - 2);
        if (all_bad || (i - 2 == c1) || (i - 2 == c2)) rdv[0] = ~rdv[0];
        ifc.rx_xfc  = 1'b1;
        ifc.rx_data = rdv;
      end
      step();
      ifc.gen_xfc = 1'b0;
      ifc.rx_xfc  = 1'b0;
      step();
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    ifc.tx_xfc  = 1'b1;
    ifc.tx_data = 32'h7000_00AA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    32'(ifc.bist_busy),      32'd0);
    chk("rst_done",    32'(ifc.bist_done),      32'd0);
    chk("rst_pass",    32'(ifc.bist_pass),      32'd0);
    chk("rst_timeout", 32'(ifc.bist_timeout),   32'd0);
    chk("rst_err",     32'(ifc.bist_err_cnt),   32'd0);
    chk("rst_grst_n",  32'(ifc.bist_gen_rst_n), 32'd0);
    chk("rst_mux",     ifc.i2si_out_data,       32'h7000_00AA);
    rst = 1'b0;
    step();
    chk("rst_release_grst_n", 32'(ifc.bist_gen_rst_n), 32'd1);

    // start ab frames  gx gen_data      tx td            rx rx_data        | busy done pass grst xfc data          err
    add(0, 0, 16'd0, 0, 32'hC0DE_0000, 1, 32'h7000_0001, 0, 32'h0,          0, 0, 0, 1, 1, 32'h7000_0001, 8'd0);
    add(1, 0, 16'd0, 0, 32'hC0DE_0000, 0, 32'h7000_0002, 0, 32'h0,          0, 1, 1, 1, 0, 32'h7000_0002, 8'd0);
    add(0, 0, 16'd0, 0, 32'hC0DE_0000, 1, 32'h7000_0003, 0, 32'h0,          0, 1, 1, 1, 1, 32'h7000_0003, 8'd0);
    add(1, 0, 16'd5, 0, 32'hC0DE_0001, 1, 32'h7000_0004, 0, 32'h0,          1, 0, 0, 0, 0, 32'hC0DE_0001, 8'd0);
    add(1, 0, 16'd0, 0, 32'hC0DE_0001, 1, 32'h7000_0005, 0, 32'h0,          1, 0, 0, 1, 0, 32'hC0DE_0001, 8'd0);
    add(0, 0, 16'd0, 1, 32'hC0DE_0002, 0, 32'h7000_0006, 0, 32'h0,          1, 0, 0, 1, 1, 32'hC0DE_0002, 8'd0);
    add(0, 0, 16'd0, 0, 32'hC0DE_0003, 0, 32'h7000_0007, 1, 32'hC0DE_0002,  1, 0, 0, 1, 0, 32'hC0DE_0003, 8'd0);
    add(1, 1, 16'd3, 1, 32'hC0DE_0004, 1, 32'h7000_0008, 0, 32'h0,          0, 0, 0, 1, 1, 32'h7000_0008, 8'd0);
    add(0, 1, 16'd0, 0, 32'hC0DE_0004, 0, 32'h7000_0009, 0, 32'h0,          0, 0, 0, 1, 0, 32'h7000_0009, 8'd0);
    add(0, 0, 16'd0, 0, 32'hC0DE_0004, 1, 32'h7000_000A, 1, 32'hC0DE_0004,  0, 0, 0, 1, 1, 32'h7000_000A, 8'd0);

    foreach (vecs[k]) begin
      ifc.rf_bist_start  = vecs[k].start;
      ifc.rf_bist_abort  = vecs[k].abort;
      ifc.rf_bist_frames = vecs[k].frames;
      ifc.gen_xfc        = vecs[k].gx;
      ifc.gen_data       = vecs[k].gd;
      ifc.tx_xfc         = vecs[k].tx;
      ifc.tx_data        = vecs[k].td;
      ifc.rx_xfc         = vecs[k].rx;
      ifc.rx_data        = vecs[k].rd;
      step();
      chk($sformatf("v%0d_busy", k),    32'(ifc.bist_busy),      32'(vecs[k].e_busy));
      chk($sformatf("v%0d_done", k),    32'(ifc.bist_done),      32'(vecs[k].e_done));
      chk($sformatf("v%0d_pass", k),    32'(ifc.bist_pass),      32'(vecs[k].e_pass));
      chk($sformatf("v%0d_grst_n", k),  32'(ifc.bist_gen_rst_n), 32'(vecs[k].e_grst));
      chk($sformatf("v%0d_out_xfc", k), 32'(ifc.i2si_out_xfc),   32'(vecs[k].e_xfc));
      chk($sformatf("v%0d_out_data", k), ifc.i2si_out_data,      vecs[k].e_data);
      chk($sformatf("v%0d_err", k),     32'(ifc.bist_err_cnt),   32'(vecs[k].e_err));
      chk($sformatf("v%0d_timeout", k), 32'(ifc.bist_timeout),   32'd0);
    end
    idle_inputs();

`ifdef I2SI_BIST_CHECK_EN
    // Two-frame loopback lag, clean data.
    run_lag(10, 0, 0, 1'b0);
    chk("lag_done",     32'(ifc.bist_done),    32'd1);
    chk("lag_pass",     32'(ifc.bist_pass),    32'd1);
    chk("lag_err",      32'(ifc.bist_err_cnt), 32'd0);
    chk("lag_busy",     32'(ifc.bist_busy),    32'd0);
    chk("lag_busy_cyc", busy_cyc,              32'd24);

    // Frames 3 and 7 corrupted.
    run_lag(10, 3, 7, 1'b0);
    chk("corrupt_done", 32'(ifc.bist_done),    32'd1);
    chk("corrupt_pass", 32'(ifc.bist_pass),    32'd0);
    chk("corrupt_err",  32'(ifc.bist_err_cnt), 32'd2);

    // Abort from DONE keeps the error count.
    ifc.rf_bist_abort = 1'b1;
    step();
    ifc.rf_bist_abort = 1'b0;
    chk("abort_done", 32'(ifc.bist_done),    32'd0);
    chk("abort_pass", 32'(ifc.bist_pass),    32'd0);
    chk("abort_err",  32'(ifc.bist_err_cnt), 32'd2);

    // RX underflow in SYNC, then a single good frame.
    start_test(1);
    chk("uf_start_err", 32'(ifc.bist_err_cnt), 32'd0);
    ifc.rx_xfc = 1'b1; ifc.rx_data = 32'h0;
    step();
    ifc.rx_xfc = 1'b0;
    chk("uf_err", 32'(ifc.bist_err_cnt), 32'd1);
    ifc.gen_xfc = 1'b1; ifc.gen_data = gd(1);
    step();
    ifc.gen_xfc = 1'b0;
    chk("uf_drain_busy", 32'(ifc.bist_busy), 32'd1);
    ifc.rx_xfc = 1'b1; ifc.rx_data = gd(1);
    step();
    ifc.rx_xfc = 1'b0;
    step();
    chk("uf_done", 32'(ifc.bist_done),    32'd1);
    chk("uf_pass", 32'(ifc.bist_pass),    32'd0);
    chk("uf_err2", 32'(ifc.bist_err_cnt), 32'd1);

    // Drain timeout: two frames, RX never answers.
    start_test(2);
    for (int i = 1; i <= 2; i++) begin
      ifc.gen_xfc = 1'b1; ifc.gen_data = gd(i);
      step();
      ifc.gen_xfc = 1'b0;
      step();
    end
    for (int p = 1; p <= 63; p++) begin
      ifc.sck_transition = 1'b1;
      step();
      ifc.sck_transition = 1'b0;
      step();
    end
    chk("to_63_busy",    32'(ifc.bist_busy),    32'd1);
    chk("to_63_timeout", 32'(ifc.bist_timeout), 32'd0);
    ifc.sck_transition = 1'b1;
    step();
    ifc.sck_transition = 1'b0;
    chk("to_64_timeout", 32'(ifc.bist_timeout), 32'd1);
    chk("to_64_done",    32'(ifc.bist_done),    32'd1);
    chk("to_64_pass",    32'(ifc.bist_pass),    32'd0);
    chk("to_64_err",     32'(ifc.bist_err_cnt), 32'd0);

    // Overflow: RX held off for all six frames of a depth-4 FIFO.
    start_test(6);
    chk("ovf_start_timeout", 32'(ifc.bist_timeout), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      ifc.gen_xfc = 1'b1; ifc.gen_data = gd(i);
      step();
      ifc.gen_xfc = 1'b0;
      step();
    end
    chk("ovf_err",  32'(ifc.bist_err_cnt), 32'd2);
    chk("ovf_busy", 32'(ifc.bist_busy),    32'd1);
    for (int i = 1; i <= 4; i++) begin
      ifc.rx_xfc = 1'b1; ifc.rx_data = gd(i);
      step();
      ifc.rx_xfc = 1'b0;
      step();
    end
    chk("ovf_done",  32'(ifc.bist_done),    32'd1);
    chk("ovf_err2",  32'(ifc.bist_err_cnt), 32'd2);
    chk("ovf_pass",  32'(ifc.bist_pass),    32'd0);

    // 300 corrupted frames saturate the error counter.
    run_lag(300, 0, 0, 1'b1);
    chk("sat_done", 32'(ifc.bist_done),    32'd1);
    chk("sat_err",  32'(ifc.bist_err_cnt), 32'hFF);
    chk("sat_pass", 32'(ifc.bist_pass),    32'd0);
`else
    // Frame counting only: RUN goes straight to DONE, RX is ignored.
    busy_cyc = 0;
    start_test(3);
    chk("nc_grst_n", 32'(ifc.bist_gen_rst_n), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      ifc.gen_xfc = 1'b1; ifc.gen_data = gd(i);
      ifc.rx_xfc  = 1'b1; ifc.rx_data  = 32'hDEAD_BEEF;
      step();
      ifc.gen_xfc = 1'b0; ifc.rx_xfc = 1'b0;
      if (i < 3) step();
    end
    chk("nc_done",     32'(ifc.bist_done),    32'd1);
    chk("nc_pass",     32'(ifc.bist_pass),    32'd1);
    chk("nc_busy",     32'(ifc.bist_busy),    32'd0);
    chk("nc_err",      32'(ifc.bist_err_cnt), 32'd0);
    chk("nc_timeout",  32'(ifc.bist_timeout), 32'd0);
    chk("nc_busy_cyc", busy_cyc,              32'd5);

    start_test(1);
    chk("nc1_busy", 32'(ifc.bist_busy), 32'd1);
    ifc.gen_xfc = 1'b1; ifc.gen_data = gd(1);
    step();
    ifc.gen_xfc = 1'b0;
    chk("nc1_done", 32'(ifc.bist_done), 32'd1);
    chk("nc1_pass", 32'(ifc.bist_pass), 32'd1);
    chk("nc1_busy_after", 32'(ifc.bist_busy), 32'd0);
`endif

    // Asynchronous reset in the middle of a run.
    start_test(5);
    ifc.gen_xfc = 1'b1; ifc.gen_data = gd(1);
    step();
    ifc.gen_xfc = 1'b0;
    chk("arst_pre_busy", 32'(ifc.bist_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   32'(ifc.bist_busy),      32'd0);
    chk("arst_grst_n", 32'(ifc.bist_gen_rst_n), 32'd0);
    chk("arst_mux",    ifc.i2si_out_data,       32'h7000_0000);
    rst = 1'b0;
    step();
    chk("arst_release_grst_n", 32'(ifc.bist_gen_rst_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
